// File: rtl/jt51_lfo_pkg.sv
// ============================================================================
// Module      : jt51_lfo_pkg
// Description : Shared waveform codes and noise LFSR constants for the LFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jt51_lfo_pkg;

    typedef enum logic [1:0] {
        W_SAW    = 2'd0,
        W_SQUARE = 2'd1,
        W_TRI    = 2'd2,
        W_NOISE  = 2'd3
    } lfo_wave_t;

    localparam int              c_lfsr_w     = 17;
    localparam int              c_lfsr_tap_a = 17;
    localparam int              c_lfsr_tap_b = 14;
    localparam logic [16:0]     c_lfsr_seed  = 17'h1_0001;

endpackage

`default_nettype wire

// File: rtl/jt51_lfo_if.sv
// ============================================================================
// Module      : jt51_lfo_if
// Description : LFO register inputs and modulation outputs (AM to EG, PM to PG).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jt51_lfo_if;
    logic [7:0] lfo_freq;
    logic [1:0] lfo_w;
    logic [6:0] lfo_amd;
    logic [6:0] lfo_pmd;
    logic       lfo_rst;
    logic [6:0] am;
    logic [7:0] pm;
    logic       lfo_step;

    modport master (
        output lfo_freq, lfo_w, lfo_amd, lfo_pmd, lfo_rst,
        input  am, pm, lfo_step
    );

    modport slave (
        input  lfo_freq, lfo_w, lfo_amd, lfo_pmd, lfo_rst,
        output am, pm, lfo_step
    );
endinterface

`default_nettype wire

// File: rtl/jt51_lfo_lfsr.sv
// ============================================================================
// Module      : jt51_lfo_lfsr
// Description : 17-bit Fibonacci LFSR (x^17 + x^14 + 1) used as the noise source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt51_lfo_lfsr
    import jt51_lfo_pkg::*;
#(
    parameter logic [c_lfsr_w-1:0] SEED = c_lfsr_seed
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                cen,
    input  wire logic                adv,
    output logic [c_lfsr_w-1:0]      lfsr
);

    logic [c_lfsr_w-1:0] r_lfsr;
    logic                w_fb;

    // The top tap is in the feedback, so the step is invertible and a
    // non-zero seed can never collapse to the all-zero lock-up state.
    assign w_fb = r_lfsr[c_lfsr_tap_a-1] ^ r_lfsr[c_lfsr_tap_b-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= SEED;
        else if (cen && adv)
            r_lfsr <= {r_lfsr[c_lfsr_w-2:0], w_fb};
    end

    assign lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/jt51_lfo_mod.sv
// ============================================================================
// Module      : jt51_lfo_mod
// Description : Frame-rate LFO: prescale/divider, four waveforms, AM/PM scaling.
//               Optional JT51_LFO_FASTTEST_EN adds test_fast (tick every frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt51_lfo_mod
    import jt51_lfo_pkg::*;
#(
    parameter logic [16:0] LFSR_SEED = c_lfsr_seed
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   cen,
    input  wire logic   zero,
`ifdef JT51_LFO_FASTTEST_EN
    input  wire logic   test_fast,
`endif
    jt51_lfo_if.slave   bus
);

    logic [4:0]          r_mant_acc;
    logic [14:0]         r_div;
    logic [7:0]          r_phase;
    logic [7:0]          r_noise_hold;
    logic [6:0]          r_am;
    logic [7:0]          r_pm;
    logic                r_step;

    logic [3:0]          w_exp;
    logic [3:0]          w_mant;
    logic [5:0]          w_sum;
    logic                w_carry;
    logic [14:0]         w_mask;
    logic                w_div_full;
    logic                w_tick;
    logic [7:0]          w_phase_nxt;
    logic [7:0]          w_noise_nxt;
    logic [7:0]          w_tri2;
    logic [7:0]          w_amp;
    logic signed [7:0]   w_pv;
    logic [14:0]         w_am_prod;
    logic signed [15:0]  w_pm_prod;
    logic [c_lfsr_w-1:0] w_lfsr;
    logic                w_unused;

    jt51_lfo_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .adv   (zero),
        .lfsr  (w_lfsr)
    );

    assign w_exp   = bus.lfo_freq[7:4];
    assign w_mant  = bus.lfo_freq[3:0];
    assign w_sum   = {1'b0, r_mant_acc} + {2'b01, w_mant};
    assign w_carry = w_sum[5];

    // Low (15-E) divider bits must be all ones; E=15 leaves an empty field.
    assign w_mask     = 15'h7FFF >> w_exp;
    assign w_div_full = (r_div & w_mask) == w_mask;

`ifdef JT51_LFO_FASTTEST_EN
    assign w_tick = !bus.lfo_rst && (test_fast || (w_carry && w_div_full));
`else
    assign w_tick = !bus.lfo_rst && w_carry && w_div_full;
`endif

    assign w_phase_nxt = bus.lfo_rst ? 8'd0 : (w_tick ? r_phase + 8'd1 : r_phase);
    assign w_noise_nxt = w_tick ? w_lfsr[7:0] : r_noise_hold;
    assign w_tri2      = {w_phase_nxt[6:0], 1'b0};

    // Waveform is derived from the post-update phase so outputs land with the tick.
    always_comb begin
        w_amp = 8'd0;
        w_pv  = 8'sd0;
        case (lfo_wave_t'(bus.lfo_w))
            W_SAW: begin
                w_amp = ~w_phase_nxt;
                w_pv  = $signed(w_phase_nxt ^ 8'h80);
            end
            W_SQUARE: begin
                w_amp = w_phase_nxt[7] ? 8'h00 : 8'hFF;
                w_pv  = w_phase_nxt[7] ? 8'sh80 : 8'sh7F;
            end
            W_TRI: begin
                w_amp = w_phase_nxt[7] ? w_tri2 : ~w_tri2;
                w_pv  = $signed((w_phase_nxt[7] ? w_tri2 : ~w_tri2) ^ 8'h80);
            end
            W_NOISE: begin
                w_amp = w_noise_nxt;
                w_pv  = $signed(w_noise_nxt ^ 8'h80);
            end
            default: ;
        endcase
    end

    assign w_am_prod = w_amp * bus.lfo_amd;
    assign w_pm_prod = w_pv * $signed({1'b0, bus.lfo_pmd});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mant_acc   <= '0;
            r_div        <= '0;
            r_phase      <= '0;
            r_noise_hold <= '0;
            r_am         <= '0;
            r_pm         <= '0;
            r_step       <= 1'b0;
        end else if (cen) begin
            r_step <= zero && w_tick;
            if (zero) begin
                if (bus.lfo_rst) begin
                    r_mant_acc <= '0;
                    r_div      <= '0;
                end else begin
                    r_mant_acc <= w_sum[4:0];
                    if (w_carry)
                        r_div <= r_div + 15'd1;
                end
                r_phase      <= w_phase_nxt;
                r_noise_hold <= w_noise_nxt;
                r_am         <= w_am_prod[14:8];
                r_pm         <= w_pm_prod[14:7];
            end
        end
    end

    assign bus.am       = r_am;
    assign bus.pm       = r_pm;
    assign bus.lfo_step = r_step;

    assign w_unused = &{1'b0, w_am_prod[7:0], w_pm_prod[15], w_pm_prod[6:0],
                        w_lfsr[c_lfsr_w-1:8]};

endmodule

`default_nettype wire

// File: tb/tb_jt51_lfo_mod.sv
// ============================================================================
// Module      : tb_jt51_lfo_mod
// Description : Scoreboard bench for jt51_lfo_mod; reference model runs per zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt51_lfo_mod;
    import jt51_lfo_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cen   = 1'b0;
    logic zero  = 1'b0;

    jt51_lfo_if bus();

`ifdef JT51_LFO_FASTTEST_EN
    logic test_fast = 1'b0;
`endif

    jt51_lfo_mod dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .zero      (zero),
`ifdef JT51_LFO_FASTTEST_EN
        .test_fast (test_fast),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] am;
        logic [7:0] pm;
        logic       step;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   errors   = 0;
    int   checks   = 0;
    int   step_cnt = 0;
    int   m_acc, m_div, m_ph, m_nh, m_lfsr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_div  = 0;
        m_ph   = 0;
        m_nh   = 0;
        m_lfsr = 'h10001;
    endtask

    // Reference model evaluated with the register values present at the zero edge.
    task automatic model_zero();
        int   e, m, sum, span, amp, pv, t, amd, pmd, amv, pmv;
        bit   tick;
        exp_t x;
        e    = bus.lfo_freq[7:4];
        m    = bus.lfo_freq[3:0];
        amd  = bus.lfo_amd;
        pmd  = bus.lfo_pmd;
        tick = 1'b0;
        if (bus.lfo_rst) begin
            m_acc = 0;
            m_div = 0;
            m_ph  = 0;
        end else begin
            sum   = m_acc + 16 + m;
            m_acc = sum % 32;
            if (sum >= 32) begin
                span  = 1 << (15 - e);
                tick  = (m_div % span) == (span - 1);
                m_div = (m_div + 1) % 32768;
            end
            if (tick) begin
                m_ph = (m_ph + 1) % 256;
                m_nh = m_lfsr % 256;
            end
        end
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1)) & 'h1FFFF;
        case (bus.lfo_w)
            2'd0: begin amp = 255 - m_ph; pv = m_ph - 128; end
            2'd1: begin
                amp = (m_ph >= 128) ? 0 : 255;
                pv  = (m_ph >= 128) ? -128 : 127;
            end
            2'd2: begin
                t   = (m_ph >= 128) ? 2 * (m_ph - 128) : 255 - 2 * m_ph;
                amp = t;
                pv  = t - 128;
            end
            default: begin amp = m_nh; pv = m_nh - 128; end
        endcase
        amv    = (amp * amd) / 256;
        pmv    = (pv * pmd) >>> 7;
        x.am   = amv[6:0];
        x.pm   = pmv[7:0];
        x.step = tick;
        sb.push_back(x);
    endtask

    // Monitor: each cen-qualified zero edge produces one output update.
    always @(posedge clk) begin
        if (rst_n && cen && zero) begin
            #1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mx = sb.pop_front();
                chk("am", int'(bus.am), int'(mx.am));
                chk("pm", int'(bus.pm), int'(mx.pm));
                chk("lfo_step", int'(bus.lfo_step), int'(mx.step));
                if (bus.lfo_step) step_cnt++;
            end
        end else if (rst_n && cen) begin
            #1;
            chk("step_pulse_width", int'(bus.lfo_step), 0);
        end
    end

    task automatic do_zero();
        @(negedge clk); cen = 1'b1; zero = 1'b1; model_zero();
        @(negedge clk); zero = 1'b0; cen = 1'b1;
        @(negedge clk); cen = 1'b0;
        @(negedge clk); cen = 1'b1;
    endtask

    task automatic run_zeros(input int n);
        for (int i = 0; i < n; i++) do_zero();
    endtask

    initial begin
        bus.lfo_freq = 8'hF0;
        bus.lfo_w    = 2'd0;
        bus.lfo_amd  = 7'd0;
        bus.lfo_pmd  = 7'd0;
        bus.lfo_rst  = 1'b0;
        model_reset();

        // Zero pulses during reset must not disturb anything.
        @(negedge clk); cen = 1'b1; zero = 1'b1;
        @(negedge clk); zero = 1'b0;
        @(negedge clk);
        chk("rst_am", int'(bus.am), 0);
        chk("rst_pm", int'(bus.pm), 0);
        chk("rst_step", int'(bus.lfo_step), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_am", int'(bus.am), 0);

        // E=15, M=0: first tick on the 2nd zero, then every other zero.
        do_zero();
        chk("f0_no_step_zero1", step_cnt, 0);
        do_zero();
        chk("f0_step_zero2", step_cnt, 1);
        bus.lfo_pmd = 7'd127;
        run_zeros(508);
        chk("saw_pm_phase255", int'(bus.pm), 126);
        run_zeros(2);
        chk("f0_ticks_512", step_cnt, 256);
        chk("saw_pm_phase0", int'(bus.pm), 8'h81);

        // E=15, M=15: 31 ticks in any 32 zeros.
        bus.lfo_freq = 8'hFF;
        step_cnt = 0;
        run_zeros(32);
        chk("ff_ticks_32", step_cnt, 31);

        // Square AM at phase 0, then held by the test bit.
        bus.lfo_w   = 2'd1;
        bus.lfo_amd = 7'd127;
        bus.lfo_pmd = 7'd0;
        bus.lfo_rst = 1'b1;
        do_zero();
        chk("square_am_low", int'(bus.am), 126);
        chk("square_pm_pmd0", int'(bus.pm), 0);
        step_cnt = 0;
        run_zeros(100);
        chk("lfo_rst_no_step", step_cnt, 0);
        chk("lfo_rst_hold_am", int'(bus.am), 126);

        bus.lfo_rst = 1'b0;
        for (int i = 0; i < 200 && m_ph < 128; i++) do_zero();
        chk("square_cross_reached", int'(m_ph >= 128), 1);
        chk("square_am_high", int'(bus.am), 0);

        // Noise depends on the LFSR having kept shifting under the test bit.
        bus.lfo_w   = 2'd3;
        bus.lfo_pmd = 7'd127;
        run_zeros(20);

        // Triangle with odd depths, exponent change mid-count.
        bus.lfo_w   = 2'd2;
        bus.lfo_amd = 7'd100;
        bus.lfo_pmd = 7'd50;
        run_zeros(20);
        bus.lfo_freq = 8'hE3;
        run_zeros(20);
        bus.lfo_freq = 8'hFA;
        run_zeros(20);

        bus.lfo_rst = 1'b1;
        bus.lfo_amd = 7'd127;
        bus.lfo_pmd = 7'd127;
        do_zero();
        chk("tri_am_phase0", int'(bus.am), 126);
        chk("tri_pm_phase0", int'(bus.pm), 126);

        // Slowest rate: no tick for a long stretch.
        bus.lfo_freq = 8'h00;
        bus.lfo_rst  = 1'b0;
        step_cnt = 0;
        run_zeros(2000);
        chk("min_rate_no_step", step_cnt, 0);

        // Asynchronous reset between clock edges.
        bus.lfo_w   = 2'd1;
        bus.lfo_rst = 1'b1;
        do_zero();
        chk("pre_areset_am", int'(bus.am), 126);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_am", int'(bus.am), 0);
        chk("areset_pm", int'(bus.pm), 0);
        chk("areset_step", int'(bus.lfo_step), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_areset_am", int'(bus.am), 0);
        do_zero();
        chk("recover_am", int'(bus.am), 126);
        bus.lfo_rst = 1'b0;
        bus.lfo_freq = 8'hF0;
        run_zeros(6);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
